// File: rtl/audio_mixer_mac_if.sv
// audio_mixer_mac_if: strobe, channel and status bundle of the stereo mixer.
// The master drives samples and controls. The slave (the mixer) returns
// the mix and its status flags.
interface audio_mixer_mac_if #(
    parameter int NCH = 8,
    parameter int IW  = 16,
    parameter int VW  = 8,
    parameter int OW  = 16
);
    logic                  sample_stb;
    logic [NCH*IW-1:0]     ch_data;
    logic [NCH*VW-1:0]     ch_vol_l;
    logic [NCH*VW-1:0]     ch_vol_r;
    logic [NCH-1:0]        ch_mute;
    logic                  mute;
    logic                  clip_clr;
    logic signed [OW-1:0]  audio_l;
    logic signed [OW-1:0]  audio_r;
    logic                  audio_valid;
    logic                  busy;
    logic                  clip_l;
    logic                  clip_r;
    logic                  overrun;

    modport master (
        output sample_stb, ch_data, ch_vol_l, ch_vol_r, ch_mute, mute, clip_clr,
        input  audio_l, audio_r, audio_valid, busy, clip_l, clip_r, overrun
    );

    modport slave (
        input  sample_stb, ch_data, ch_vol_l, ch_vol_r, ch_mute, mute, clip_clr,
        output audio_l, audio_r, audio_valid, busy, clip_l, clip_r, overrun
    );
endinterface

// File: rtl/audio_mixer_mac.sv
// audio_mixer_mac: NCH-channel stereo mixer built on one time-multiplexed MAC.
// Each channel is accumulated with its own left and right volume, one channel
// per clock. The result is then floor-shifted by VW-1, saturated to OW bits
// and presented with a one-cycle audio_valid pulse.
// Optional: define MIXER_DC_BLOCK_EN to add a per-side first-order DC-blocking
// high-pass after saturation. The filter adds one state (DCB) to the latency.
module audio_mixer_mac #(
    parameter int NCH      = 8,
    parameter int IW       = 16,
    parameter int VW       = 8,
    parameter int OW       = 16,
    parameter int DC_SHIFT = 10
) (
    input  logic              clk,
    input  logic              rst,
    audio_mixer_mac_if.slave  bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = IW + VW + 1;            // one product
    localparam int AW = PW + $clog2(NCH);       // sum of NCH products, never overflows
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [AW-1:0] AMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

`ifdef MIXER_DC_BLOCK_EN
    typedef enum logic [2:0] {IDLE, ACC, SAT, DCB, OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;
`endif

    state_t state, state_nx;

    logic [NCH*IW-1:0]    snap_data;
    logic [NCH*VW-1:0]    snap_vol_l, snap_vol_r;
    logic [NCH-1:0]       snap_mute;
    logic [CW-1:0]        idx;
    logic signed [AW-1:0] acc_l, acc_r;
    logic signed [OW-1:0] sat_l, sat_r;
    logic signed [OW-1:0] out_l, out_r;

    // Clamp a shifted accumulator to OW bits; MSB of the result is the clip flag.
    function automatic logic [OW:0] sat_acc(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> (VW - 1);
        if (s > AMAX)      return {1'b1, OMAX};
        else if (s < AMIN) return {1'b1, OMIN};
        else               return {1'b0, s[OW-1:0]};
    endfunction

    // Channel currently addressed by idx, taken from the snapshot, and its two products
    logic signed [IW-1:0] cur_d;
    logic [VW-1:0]        cur_vl, cur_vr;
    logic                 cur_m;
    logic signed [PW-1:0] d_x, vl_x, vr_x, prod_l, prod_r;
    always_comb begin
        cur_d  = snap_data[int'(idx)*IW +: IW];
        cur_vl = snap_vol_l[int'(idx)*VW +: VW];
        cur_vr = snap_vol_r[int'(idx)*VW +: VW];
        cur_m  = snap_mute[idx];
        d_x    = {{(VW+1){cur_d[IW-1]}}, cur_d};
        vl_x   = {{(IW+1){1'b0}}, cur_vl};
        vr_x   = {{(IW+1){1'b0}}, cur_vr};
        prod_l = cur_m ? '0 : d_x * vl_x;
        prod_r = cur_m ? '0 : d_x * vr_x;
    end

    // Saturation of both accumulators, consumed at the SAT edge
    logic [OW:0] sat_nx_l, sat_nx_r;
    always_comb begin
        sat_nx_l = sat_acc(acc_l);
        sat_nx_r = sat_acc(acc_r);
    end

`ifdef MIXER_DC_BLOCK_EN
    // y carries 8 fractional bits and 2 guard bits; TW holds the unclamped sum.
    localparam int YW = OW + 10;
    localparam int TW = YW + 2;
    localparam logic signed [TW-1:0] TMAX = {3'b000, {(YW-1){1'b1}}};
    localparam logic signed [TW-1:0] TMIN = {3'b111, {(YW-1){1'b0}}};
    localparam logic signed [YW-1:0] YMAX = {{(YW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [YW-1:0] YMIN = {{(YW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [OW-1:0] x_prev_l, x_prev_r, dc_l, dc_r;
    logic signed [YW-1:0] y_prev_l, y_prev_r, y_new_l, y_new_r;

    // One filter step: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), kept in YW bits
    function automatic logic signed [YW-1:0] dc_step(input logic signed [OW-1:0] x,
                                                     input logic signed [OW-1:0] xp,
                                                     input logic signed [YW-1:0] yp);
        logic signed [TW-1:0] t;
        logic signed [YW-1:0] yd;
        yd = yp >>> DC_SHIFT;
        t  = {{4{x[OW-1]}}, x, 8'd0} - {{4{xp[OW-1]}}, xp, 8'd0}
           + {{2{yp[YW-1]}}, yp} - {{2{yd[YW-1]}}, yd};
        if (t > TMAX)      return TMAX[YW-1:0];
        else if (t < TMIN) return TMIN[YW-1:0];
        else               return t[YW-1:0];
    endfunction

    // Drop the fraction and re-saturate to OW; MSB is the clip flag.
    function automatic logic [OW:0] sat_y(input logic signed [YW-1:0] y);
        logic signed [YW-1:0] s;
        s = y >>> 8;
        if (s > YMAX)      return {1'b1, OMAX};
        else if (s < YMIN) return {1'b1, OMIN};
        else               return {1'b0, s[OW-1:0]};
    endfunction

    logic signed [YW-1:0] y_nx_l, y_nx_r;
    logic [OW:0]          dc_nx_l, dc_nx_r;
    // Filter step on the saturated sample, consumed at the DCB edge
    always_comb begin
        y_nx_l  = dc_step(sat_l, x_prev_l, y_prev_l);
        y_nx_r  = dc_step(sat_r, x_prev_r, y_prev_r);
        dc_nx_l = sat_y(y_nx_l);
        dc_nx_r = sat_y(y_nx_r);
    end

    // Filter pipeline and history; history commits only when a mix reaches OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_l     <= '0;
            dc_r     <= '0;
            y_new_l  <= '0;
            y_new_r  <= '0;
            x_prev_l <= '0;
            x_prev_r <= '0;
            y_prev_l <= '0;
            y_prev_r <= '0;
        end else if (state == DCB) begin
            dc_l    <= dc_nx_l[OW-1:0];
            dc_r    <= dc_nx_r[OW-1:0];
            y_new_l <= y_nx_l;
            y_new_r <= y_nx_r;
        end else if (state == OUT) begin
            x_prev_l <= sat_l;
            x_prev_r <= sat_r;
            y_prev_l <= y_new_l;
            y_prev_r <= y_new_r;
        end
    end

    assign out_l = dc_l;
    assign out_r = dc_r;
    wire set_l = ((state == SAT) && sat_nx_l[OW]) || ((state == DCB) && dc_nx_l[OW]);
    wire set_r = ((state == SAT) && sat_nx_r[OW]) || ((state == DCB) && dc_nx_r[OW]);
`else
    assign out_l = sat_l;
    assign out_r = sat_r;
    wire set_l = (state == SAT) && sat_nx_l[OW];
    wire set_r = (state == SAT) && sat_nx_r[OW];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: snapshot, NCH accumulate cycles, saturate, (filter), present
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.sample_stb) state_nx = ACC;
            ACC:     if (idx == LAST) state_nx = SAT;
`ifdef MIXER_DC_BLOCK_EN
            SAT:     state_nx = DCB;
            DCB:     state_nx = OUT;
`else
            SAT:     state_nx = OUT;
`endif
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Snapshot, MAC accumulation and saturation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data  <= '0;
            snap_vol_l <= '0;
            snap_vol_r <= '0;
            snap_mute  <= '0;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            sat_l      <= '0;
            sat_r      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.sample_stb) begin
                    snap_data  <= bus.ch_data;
                    snap_vol_l <= bus.ch_vol_l;
                    snap_vol_r <= bus.ch_vol_r;
                    snap_mute  <= bus.ch_mute;
                    idx        <= '0;
                    acc_l      <= '0;
                    acc_r      <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + {{(AW-PW){prod_l[PW-1]}}, prod_l};
                    acc_r <= acc_r + {{(AW-PW){prod_r[PW-1]}}, prod_r};
                    idx   <= idx + CW'(1);
                end
                SAT: begin
                    sat_l <= sat_nx_l[OW-1:0];
                    sat_r <= sat_nx_r[OW-1:0];
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clip_clr wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.clip_l  <= 1'b0;
            bus.clip_r  <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            if (set_l)             bus.clip_l <= 1'b1;
            else if (bus.clip_clr) bus.clip_l <= 1'b0;
            if (set_r)             bus.clip_r <= 1'b1;
            else if (bus.clip_clr) bus.clip_r <= 1'b0;
            if (bus.sample_stb && (state != IDLE)) bus.overrun <= 1'b1;
            else if (bus.clip_clr)                 bus.overrun <= 1'b0;
        end
    end

    // Output registers; busy rises one edge after the snapshot edge and drops as the result appears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.audio_l     <= '0;
            bus.audio_r     <= '0;
            bus.audio_valid <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.audio_valid <= (state == OUT);
            bus.busy        <= (state != IDLE) && (state != OUT);
            if (state == OUT) begin
                bus.audio_l <= bus.mute ? '0 : out_l;
                bus.audio_r <= bus.mute ? '0 : out_r;
            end
        end
    end
endmodule

// File: tb/tb_audio_mixer_mac.sv
// Directed bench for audio_mixer_mac (NCH=8, IW=16, VW=8, OW=16).
// Hand-computed vectors cover latency, busy, gain, saturation, mutes, overrun and reset.
module tb_audio_mixer_mac;
    localparam int NCH = 8;
    localparam int IW  = 16;
    localparam int VW  = 8;
    localparam int OW  = 16;
`ifdef MIXER_DC_BLOCK_EN
    localparam int LAT = NCH + 3;
`else
    localparam int LAT = NCH + 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    audio_mixer_mac_if #(.NCH(NCH), .IW(IW), .VW(VW), .OW(OW)) bus();

    audio_mixer_mac #(.NCH(NCH), .IW(IW), .VW(VW), .OW(OW), .DC_SHIFT(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input int d, input int vl, input int vr);
        logic [31:0] t;
        t = d;  bus.ch_data[i*IW +: IW]  = t[IW-1:0];
        t = vl; bus.ch_vol_l[i*VW +: VW] = t[VW-1:0];
        t = vr; bus.ch_vol_r[i*VW +: VW] = t[VW-1:0];
    endtask

    task automatic clear_ch();
        bus.ch_data  = '0;
        bus.ch_vol_l = '0;
        bus.ch_vol_r = '0;
        bus.ch_mute  = '0;
    endtask

    // Strobe once, optionally scramble inputs after the snapshot edge, wait for audio_valid.
    task automatic do_mix(input bit scramble, output int lat, output int bcnt);
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
        if (scramble) begin
            bus.ch_data = '1;
            bus.ch_mute = '0;
        end
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.audio_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic clr_flags();
        @(negedge clk);
        bus.clip_clr = 1'b1;
        @(negedge clk);
        bus.clip_clr = 1'b0;
    endtask

    initial begin
        int lat, bcnt, vcnt, prev;
        bus.sample_stb = 1'b0;
        bus.mute       = 1'b0;
        bus.clip_clr   = 1'b0;
        clear_ch();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio_l", 32'($signed(bus.audio_l)), 0);
        chk("rst_audio_r", 32'($signed(bus.audio_r)), 0);
        chk("rst_valid",   32'(bus.audio_valid), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_clip_l",  32'(bus.clip_l), 0);
        chk("rst_clip_r",  32'(bus.clip_r), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef MIXER_DC_BLOCK_EN
        // Constant +1000 at unity: step through the high-pass, decaying toward 0
        set_ch(0, 1000, 128, 128);
        do_mix(1'b0, lat, bcnt);
        chk("dc_latency", lat, LAT);
        chk("dc_first",   32'($signed(bus.audio_l)), 1000);
        do_mix(1'b0, lat, bcnt);
        chk("dc_second",  32'($signed(bus.audio_l)), 999);
        prev = 999;
        for (int k = 0; k < 40; k++) begin
            do_mix(1'b0, lat, bcnt);
            chk("dc_nonincr", 32'($signed(bus.audio_l) <= prev), 1);
            prev = $signed(bus.audio_l);
        end
        chk("dc_decayed", 32'(prev < 999), 1);
`else
        // Unity gain left, half gain right; inputs scrambled after the snapshot edge
        set_ch(0, 1000, 128, 64);
        do_mix(1'b1, lat, bcnt);
        chk("unity_latency", lat, LAT);
        chk("unity_busy_cycles", bcnt, LAT - 1);
        chk("unity_l", 32'($signed(bus.audio_l)), 1000);
        chk("unity_r", 32'($signed(bus.audio_r)), 500);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_l", 32'($signed(bus.audio_l)), 1000);
        chk("hold_valid_low", 32'(bus.audio_valid), 0);

        // Positive saturation: 8 * 20000 * 128 >>> 7 = 160000
        for (int i = 0; i < NCH; i++) set_ch(i, 20000, 128, 128);
        do_mix(1'b0, lat, bcnt);
        chk("possat_l", 32'($signed(bus.audio_l)), 32767);
        chk("possat_r", 32'($signed(bus.audio_r)), 32767);
        chk("possat_clip_l", 32'(bus.clip_l), 1);
        chk("possat_clip_r", 32'(bus.clip_r), 1);
        for (int i = 0; i < NCH; i++) set_ch(i, 0, 128, 128);
        do_mix(1'b0, lat, bcnt);
        chk("zero_l", 32'($signed(bus.audio_l)), 0);
        chk("zero_clip_sticky", 32'(bus.clip_l), 1);
        clr_flags();
        #1;
        chk("clr_clip_l", 32'(bus.clip_l), 0);
        chk("clr_clip_r", 32'(bus.clip_r), 0);

        // Floor rounding: -1 * 1 >>> 7 = -1
        clear_ch();
        set_ch(0, -1, 1, 0);
        do_mix(1'b0, lat, bcnt);
        chk("floor_l", 32'($signed(bus.audio_l)), -1);
        chk("floor_r", 32'($signed(bus.audio_r)), 0);
        chk("floor_noclip", 32'(bus.clip_l), 0);

        // Negative saturation: 8 * -32768 * 255 >>> 7 = -522240
        for (int i = 0; i < NCH; i++) set_ch(i, -32768, 255, 255);
        do_mix(1'b0, lat, bcnt);
        chk("negsat_l", 32'($signed(bus.audio_l)), -32768);
        chk("negsat_clip_l", 32'(bus.clip_l), 1);
        chk("negsat_clip_r", 32'(bus.clip_r), 1);
        clr_flags();

        // Channel mute: ch0 muted, ch1 passes at unity
        clear_ch();
        set_ch(0, 5000, 128, 128);
        set_ch(1, 100, 128, 128);
        bus.ch_mute[0] = 1'b1;
        do_mix(1'b0, lat, bcnt);
        chk("chmute_l", 32'($signed(bus.audio_l)), 100);
        chk("chmute_r", 32'($signed(bus.audio_r)), 100);

        // Master mute raised only during the OUT cycle
        clear_ch();
        set_ch(0, 5000, 128, 128);
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        bus.mute = 1'b1;
        @(posedge clk);
        #1;
        chk("mute_valid", 32'(bus.audio_valid), 1);
        chk("mute_l", 32'($signed(bus.audio_l)), 0);
        chk("mute_r", 32'($signed(bus.audio_r)), 0);
        bus.mute = 1'b0;
        do_mix(1'b0, lat, bcnt);
        chk("unmute_l", 32'($signed(bus.audio_l)), 5000);

        // Overrun: second strobe 3 clocks in, with clip_clr in the same cycle
        set_ch(0, 1000, 128, 128);
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.sample_stb = 1'b1;
        bus.clip_clr   = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
        bus.clip_clr   = 1'b0;
        chk("overrun_set_wins", 32'(bus.overrun), 1);
        repeat (LAT - 3) @(posedge clk);
        #1;
        chk("overrun_valid", 32'(bus.audio_valid), 1);
        chk("overrun_l", 32'($signed(bus.audio_l)), 1000);
        vcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.audio_valid) vcnt++;
        end
        chk("overrun_no_second", vcnt, 0);
        chk("overrun_sticky", 32'(bus.overrun), 1);
        clr_flags();
        #1;
        chk("overrun_clr", 32'(bus.overrun), 0);

        // Reset during ACC idx 4 aborts the mix
        set_ch(0, 3000, 128, 128);
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_l", 32'($signed(bus.audio_l)), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.audio_valid || bus.busy) vcnt++;
        end
        chk("midrst_no_valid", vcnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
